eth_tx_scheduler: RTL

- Round-robin frame scheduler that shares the single Ethernet frame packer between two payload sources (src0, src1).
- Each source holds one complete PAYLOAD_BYTES payload in a 1-cycle-latency read buffer and raises req.
- The block grants one source and gates the packer through its cancel input. It streams the granted payload into the packer as dibits, paced by the packer's stall, then reports completion to that source.

---
 rtl/eth_tx_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler sharing one Ethernet frame packer between two payload sources.
// Streams the granted source's buffer into the packer as dibits, LSB dibit of each byte first.
module eth_tx_scheduler #(
  parameter int PAYLOAD_BYTES   = 320,
  parameter int WATCHDOG_CYCLES = 255,
  parameter int ADDR_W          = $clog2(PAYLOAD_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              timeout,
  output logic [1:0]        rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data0,
  input  logic [7:0]        rd_data1,
  input  logic              packer_stall,
  input  logic              packer_txen,
  output logic              packer_cancel,
  output logic              packer_axiiv,
  output logic [1:0]        packer_axiid,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W  = 13;
  localparam int BYTE_W = CNT_W - 2;
  localparam int WD_W   = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_DIBIT = CNT_W'(4 * PAYLOAD_BYTES - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(PAYLOAD_BYTES - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DATA  = 2'd2,
    S_TAIL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               cancel_q, cancel_d;
  logic               axiiv_q, axiiv_d;
  logic [1:0]         axiid_q, axiid_d;
  logic               rr_q, rr_d;
  logic               gsel_q, gsel_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [7:0]         cur_byte_q, cur_byte_d;
  logic [7:0]         nxt_byte_q, nxt_byte_d;
  logic               byte_valid_q, byte_valid_d;
  logic               rd_pend_q;
  logic               txen_q;
  logic [7:0]         rd_byte;
  logic               pick;

  // Packer pacing: a cycle with packer_stall low is a transfer cycle; the axiiv/axiid
  // register is reloaded only then and otherwise holds, so the packer consumes each
  // loaded dibit exactly once, in the cycle after the stall-low cycle that loaded it.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = 2'b00;
    timeout_d    = 1'b0;
    rd_en_d      = 2'b00;
    rd_addr_d    = rd_addr_q;
    cancel_d     = cancel_q;
    axiiv_d      = axiiv_q;
    axiid_d      = axiid_q;
    rr_d         = rr_q;
    gsel_d       = gsel_q;
    wd_d         = wd_q;
    cnt_d        = cnt_q;
    nxt_cnt      = cnt_q + CNT_W'(1);
    cur_byte_d   = cur_byte_q;
    nxt_byte_d   = nxt_byte_q;
    byte_valid_d = byte_valid_q;
    pick         = 1'b0;
    rd_byte      = gsel_q ? rd_data1 : rd_data0;

    // Byte 0 lands straight in the shift register; later bytes wait in the next-byte slot.
    if (rd_pend_q) begin
      if (state_q == S_ARMED) begin
        cur_byte_d   = rd_byte;
        byte_valid_d = 1'b1;
      end else begin
        nxt_byte_d = rd_byte;
      end
    end

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b1;
        if (req != 2'b00) begin
          pick         = (req == 2'b11) ? rr_q : req[1];
          gsel_d       = pick;
          grant_d      = pick ? 2'b10 : 2'b01;
          rd_en_d      = pick ? 2'b10 : 2'b01;
          rd_addr_d    = '0;
          wd_d         = '0;
          cnt_d        = '0;
          byte_valid_d = 1'b0;
          cancel_d     = 1'b0;
          state_d      = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!packer_stall && byte_valid_q) begin
          axiiv_d = 1'b1;
          axiid_d = cur_byte_q[1:0];
          cnt_d   = '0;
          state_d = S_DATA;
          if (PAYLOAD_BYTES > 1) begin
            rd_en_d   = grant_q;
            rd_addr_d = ADDR_W'(1);
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          grant_d   = 2'b00;
          cancel_d  = 1'b1;
          rr_d      = ~gsel_q;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DATA: begin
        if (!packer_stall) begin
          if (cnt_q == LAST_DIBIT) begin
            axiiv_d = 1'b0;
            axiid_d = 2'b00;
            state_d = S_TAIL;
          end else begin
            cnt_d = nxt_cnt;
            case (nxt_cnt[1:0])
              2'd0: begin
                cur_byte_d = nxt_byte_q;
                axiid_d    = nxt_byte_q[1:0];
                if (nxt_cnt[CNT_W-1:2] < LAST_BYTE) begin
                  rd_en_d   = grant_q;
                  rd_addr_d = ADDR_W'(nxt_cnt[CNT_W-1:2] + BYTE_W'(1));
                end
              end
              2'd1:    axiid_d = cur_byte_q[3:2];
              2'd2:    axiid_d = cur_byte_q[5:4];
              default: axiid_d = cur_byte_q[7:6];
            endcase
          end
        end
      end
      S_TAIL: begin
        // rr holds the source preferred next, so the finished source yields to the other.
        if (txen_q && !packer_txen) begin
          done_d   = grant_q;
          grant_d  = 2'b00;
          rr_d     = ~gsel_q;
          cancel_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      done_q       <= 2'b00;
      timeout_q    <= 1'b0;
      rd_en_q      <= 2'b00;
      rd_addr_q    <= '0;
      cancel_q     <= 1'b1;
      axiiv_q      <= 1'b0;
      axiid_q      <= 2'b00;
      rr_q         <= 1'b0;
      gsel_q       <= 1'b0;
      wd_q         <= '0;
      cnt_q        <= '0;
      cur_byte_q   <= 8'h00;
      nxt_byte_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      txen_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      cancel_q     <= cancel_d;
      axiiv_q      <= axiiv_d;
      axiid_q      <= axiid_d;
      rr_q         <= rr_d;
      gsel_q       <= gsel_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      cur_byte_q   <= cur_byte_d;
      nxt_byte_q   <= nxt_byte_d;
      byte_valid_q <= byte_valid_d;
      rd_pend_q    <= |rd_en_q;
      txen_q       <= packer_txen;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign packer_cancel = cancel_q;
  assign packer_axiiv  = axiiv_q;
  assign packer_axiid  = axiid_q;
  assign dbg_state     = state_q;

endmodule
